// File: rtl/slider_pkg.sv
// Shared types and constants for the slider stepper: FSM states and the
// per-channel step-size lookup.
package slider_pkg;

   typedef enum logic {
      StIdle,
      StHold
   } state_e;

   // Step size for channel ch is 10**ch.
   localparam int unsigned StepLut [4] = '{1, 10, 100, 1000};

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, cleared by reset.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/slider_stepper.sv
// Slider-driven up/down counter: a press steps immediately by 10**channel,
// holding auto-repeats every PERIOD cycles; wraps or saturates at the limits.
module slider_stepper
   import slider_pkg::*;
#(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned WIDTH   = 14,
   parameter int unsigned PERIOD  = 32500000,
   parameter int unsigned MAX_VAL = 9999,
   parameter int unsigned WRAP    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] slider,
   input  logic              down,
   input  logic              clr,
   output logic [WIDTH-1:0]  number,
   output logic              step_pulse,
   output logic              limit_hit
);

   localparam int unsigned TW = $clog2(PERIOD);
   localparam logic [WIDTH:0] MaxExt = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0] ModExt = (WIDTH+1)'(MAX_VAL + 1);
   localparam logic [TW-1:0] TimerLast = TW'(PERIOD - 1);

   logic [NUM_CH:0]   sync_in;
   logic [NUM_CH:0]   sync_out;
   logic [NUM_CH-1:0] slider_s;
   logic              down_s;

   assign sync_in = {down, slider};

   sync_2ff #(
      .WIDTH(NUM_CH + 1)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d_i  (sync_in),
      .q_o  (sync_out)
   );

   assign slider_s = sync_out[NUM_CH-1:0];
   assign down_s   = sync_out[NUM_CH];

   state_e           state_q, state_d;
   logic [1:0]       ch_q, ch_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [WIDTH-1:0] number_q, number_d;
   logic             step_pulse_q, step_pulse_d;
   logic             limit_hit_q, limit_hit_d;

   logic       act_valid;
   logic [1:0] act_ch;

   // Descending scan so the lowest asserted bit wins.
   always_comb begin
      act_valid = 1'b0;
      act_ch    = '0;
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (slider_s[i]) begin
            act_valid = 1'b1;
            act_ch    = 2'(i);
         end
      end
   end

   logic [WIDTH:0] step_ext;
   logic [WIDTH:0] num_ext;
   logic [WIDTH:0] sum_ext;
   logic [WIDTH:0] stepped;
   logic           crossed;

   // One extra bit keeps number+step and number+MAX_VAL+1 from overflowing.
   always_comb begin
      step_ext = (WIDTH+1)'(StepLut[act_ch]);
      num_ext  = {1'b0, number_q};
      sum_ext  = num_ext + step_ext;
      crossed  = 1'b0;
      stepped  = sum_ext;
      if (!down_s) begin
         if (sum_ext > MaxExt) begin
            crossed = 1'b1;
            stepped = (WRAP != 0) ? (sum_ext - ModExt) : MaxExt;
         end
      end else begin
         if (num_ext < step_ext) begin
            crossed = 1'b1;
            stepped = (WRAP != 0) ? (num_ext + ModExt - step_ext) : '0;
         end else begin
            stepped = num_ext - step_ext;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      timer_d      = timer_q;
      number_d     = number_q;
      step_pulse_d = 1'b0;
      limit_hit_d  = 1'b0;
      if (clr) begin
         number_d = '0;
         timer_d  = '0;
         state_d  = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (act_valid) begin
                  step_pulse_d = 1'b1;
                  ch_d         = act_ch;
                  timer_d      = '0;
                  state_d      = StHold;
               end
            end
            StHold: begin
               if (!act_valid) begin
                  timer_d = '0;
                  state_d = StIdle;
               end else if (act_ch != ch_q) begin
                  step_pulse_d = 1'b1;
                  ch_d         = act_ch;
                  timer_d      = '0;
               end else if (timer_q == TimerLast) begin
                  step_pulse_d = 1'b1;
                  timer_d      = '0;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            default: state_d = StIdle;
         endcase
         if (step_pulse_d) begin
            number_d    = WIDTH'(stepped);
            limit_hit_d = crossed;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         ch_q         <= '0;
         timer_q      <= '0;
         number_q     <= '0;
         step_pulse_q <= 1'b0;
         limit_hit_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         timer_q      <= timer_d;
         number_q     <= number_d;
         step_pulse_q <= step_pulse_d;
         limit_hit_q  <= limit_hit_d;
      end
   end

   assign number     = number_q;
   assign step_pulse = step_pulse_q;
   assign limit_hit  = limit_hit_q;

endmodule

// File: tb/tb_slider_stepper.sv
// Bench for slider_stepper: a wrapping and a saturating instance share stimulus
// and are compared every cycle against a cycle-level reference model.
module tb_slider_stepper;

   localparam int unsigned NumCh  = 4;
   localparam int unsigned Width  = 14;
   localparam int          Period = 5;
   localparam int          MaxVal = 9999;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [3:0]       slider = '0;
   logic             down = 1'b0;
   logic             clr = 1'b0;
   logic [Width-1:0] num_w, num_s;
   logic             sp_w, sp_s, lh_w, lh_s;

   always #5 clk = ~clk;

   slider_stepper #(
      .NUM_CH (NumCh),
      .WIDTH  (Width),
      .PERIOD (Period),
      .MAX_VAL(MaxVal),
      .WRAP   (1)
   ) u_dut_wrap (
      .clk       (clk),
      .rst_n     (rst_n),
      .slider    (slider),
      .down      (down),
      .clr       (clr),
      .number    (num_w),
      .step_pulse(sp_w),
      .limit_hit (lh_w)
   );

   slider_stepper #(
      .NUM_CH (NumCh),
      .WIDTH  (Width),
      .PERIOD (Period),
      .MAX_VAL(MaxVal),
      .WRAP   (0)
   ) u_dut_sat (
      .clk       (clk),
      .rst_n     (rst_n),
      .slider    (slider),
      .down      (down),
      .clr       (clr),
      .number    (num_s),
      .step_pulse(sp_s),
      .limit_hit (lh_s)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: index 0 = wrapping instance, 1 = saturating instance.
   logic [3:0] hist_sl [2] = '{4'b0, 4'b0};
   bit         hist_dn [2] = '{1'b0, 1'b0};
   int         m_held = -1;
   int         m_cnt  = 0;
   int         m_num [2] = '{0, 0};
   bit         m_pulse = 1'b0;
   bit         m_lim [2] = '{1'b0, 1'b0};

   function automatic int lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic apply(input int n, input int s, input bit dn, input bit wrap,
                        output int nn, output bit lim);
      lim = 1'b0;
      if (!dn) begin
         nn = n + s;
         if (n + s > MaxVal) begin
            lim = 1'b1;
            nn  = wrap ? (n + s) % (MaxVal + 1) : MaxVal;
         end
      end else begin
         nn = n - s;
         if (n < s) begin
            lim = 1'b1;
            nn  = wrap ? (n - s + MaxVal + 1) % (MaxVal + 1) : 0;
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         hist_sl = '{4'b0, 4'b0};
         hist_dn = '{1'b0, 1'b0};
         m_held  = -1;
         m_cnt   = 0;
         m_num   = '{0, 0};
         m_pulse = 1'b0;
         m_lim   = '{1'b0, 1'b0};
      end else begin
         logic [3:0] sl;
         bit dn, take, lim;
         int a, nn;
         sl = hist_sl[1];
         dn = hist_dn[1];
         hist_sl[1] = hist_sl[0];
         hist_dn[1] = hist_dn[0];
         hist_sl[0] = slider;
         hist_dn[0] = down;
         m_pulse = 1'b0;
         m_lim   = '{1'b0, 1'b0};
         take    = 1'b0;
         if (clr) begin
            m_num  = '{0, 0};
            m_held = -1;
            m_cnt  = 0;
         end else begin
            a = lowest(sl);
            if (a < 0) begin
               m_held = -1;
            end else if (a != m_held) begin
               take   = 1'b1;
               m_held = a;
               m_cnt  = 0;
            end else begin
               m_cnt++;
               if (m_cnt == Period) begin
                  take  = 1'b1;
                  m_cnt = 0;
               end
            end
            if (take) begin
               m_pulse = 1'b1;
               for (int k = 0; k < 2; k++) begin
                  apply(m_num[k], 10 ** a, dn, (k == 0), nn, lim);
                  m_num[k] = nn;
                  m_lim[k] = lim;
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("w_number", int'(num_w), m_num[0]);
         check("s_number", int'(num_s), m_num[1]);
         check("w_step_pulse", int'(sp_w), int'(m_pulse));
         check("s_step_pulse", int'(sp_s), int'(m_pulse));
         check("w_limit_hit", int'(lh_w), int'(m_lim[0]));
         check("s_limit_hit", int'(lh_s), int'(m_lim[1]));
      end
   end

   task automatic do_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
   endtask

   // Hold channel ch just long enough for exactly n steps, then release.
   task automatic hold_steps(input int ch, input int n);
      if (n > 0) begin
         slider = 4'(1 << ch);
         repeat (Period * (n - 1) + 1) @(negedge clk);
         slider = '0;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic preset(input int v);
      do_clr();
      for (int ch = 3; ch >= 0; ch--) hold_steps(ch, (v / (10 ** ch)) % 10);
   endtask

   typedef struct {
      int preset;
      bit dn;
      int ch;
      int exp_w;
      int exp_s;
      bit exp_lim;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int pulses, first;
      bit seen_lw, seen_ls;
      int q [$];

      vecs[0] = '{9995, 1'b0, 1, 5,    9999, 1'b1};
      vecs[1] = '{3,    1'b1, 1, 9993, 0,    1'b1};
      vecs[2] = '{1234, 1'b0, 2, 1334, 1334, 1'b0};
      vecs[3] = '{1234, 1'b1, 3, 234,  234,  1'b0};
      vecs[4] = '{0,    1'b1, 0, 9999, 0,    1'b1};
      vecs[5] = '{9999, 1'b0, 0, 0,    9999, 1'b1};
      vecs[6] = '{500,  1'b1, 2, 400,  400,  1'b0};
      vecs[7] = '{9000, 1'b0, 3, 0,    9999, 1'b1};
      vecs[8] = '{99,   1'b1, 1, 89,   89,   1'b0};
      vecs[9] = '{9999, 1'b1, 3, 8999, 8999, 1'b0};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_number_w", int'(num_w), 0);
      check("rst_number_s", int'(num_s), 0);
      check("rst_step_pulse", int'(sp_w), 0);
      check("rst_limit_hit", int'(lh_w), 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      repeat (4) @(negedge clk);

      // Table of single taps from a preset value.
      for (int i = 0; i < 10; i++) begin
         preset(vecs[i].preset);
         check($sformatf("vec%0d_preset", i), int'(num_w), vecs[i].preset);
         down   = vecs[i].dn;
         slider = 4'(1 << vecs[i].ch);
         @(negedge clk);
         slider  = '0;
         pulses  = 0;
         seen_lw = 1'b0;
         seen_ls = 1'b0;
         repeat (4) begin
            @(negedge clk);
            pulses += int'(sp_w);
            seen_lw |= lh_w;
            seen_ls |= lh_s;
         end
         down = 1'b0;
         check($sformatf("vec%0d_number_wrap", i), int'(num_w), vecs[i].exp_w);
         check($sformatf("vec%0d_number_sat", i), int'(num_s), vecs[i].exp_s);
         check($sformatf("vec%0d_limit_wrap", i), int'(seen_lw), int'(vecs[i].exp_lim));
         check($sformatf("vec%0d_limit_sat", i), int'(seen_ls), int'(vecs[i].exp_lim));
         check($sformatf("vec%0d_pulses", i), pulses, 1);
      end

      // Auto-repeat: 12 cycles of hold -> steps at t0, t0+5, t0+10.
      do_clr();
      slider = 4'b0001;
      q.delete();
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (sp_w) q.push_back(c);
         if (c == 12) slider = '0;
      end
      check("repeat_pulse_count", q.size(), 3);
      if (q.size() == 3) begin
         check("repeat_t0", q[0], 3);
         check("repeat_t5", q[1], 8);
         check("repeat_t10", q[2], 13);
      end
      check("repeat_number", int'(num_w), 3);

      // Priority: lower channel wins; releasing it steps the next at once.
      do_clr();
      slider = 4'b0101;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (c == 12) slider = 4'b0100;
         if (c == 14) check("prio_only_ones", int'(num_w), 3);
         if (c == 15) begin
            check("prio_switch_number", int'(num_w), 103);
            check("prio_switch_pulse", int'(sp_w), 1);
         end
      end
      slider = '0;
      repeat (3) @(negedge clk);

      // Asynchronous reset mid-hold, slider kept held.
      do_clr();
      slider = 4'b0001;
      repeat (33) @(negedge clk);
      check("hold_before_rst", int'(num_w), 7);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_number_w", int'(num_w), 0);
      check("async_rst_number_s", int'(num_s), 0);
      @(negedge clk);
      rst_n = 1'b1;
      first = -1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (sp_w && first < 0) first = c;
      end
      check("rst_first_step_cycle", int'(first >= 2 && first <= 3), 1);
      check("rst_after_number", int'(num_w), 1);
      slider = '0;
      repeat (3) @(negedge clk);

      // clr coinciding with a due repeat step.
      do_clr();
      slider = 4'b0001;
      repeat (7) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      check("clr_due_number", int'(num_w), 0);
      check("clr_due_no_pulse_w", int'(sp_w), 0);
      check("clr_due_no_pulse_s", int'(sp_s), 0);
      clr = 1'b0;
      @(negedge clk);
      check("clr_next_number", int'(num_w), 1);
      check("clr_next_pulse", int'(sp_w), 1);
      slider = '0;
      repeat (3) @(negedge clk);

      // Random stimulus, checked every cycle against the model.
      for (int it = 0; it < 300; it++) begin
         slider = ($urandom_range(0, 9) < 3) ? 4'b0 : 4'($urandom_range(0, 15));
         down   = 1'($urandom_range(0, 1));
         clr    = ($urandom_range(0, 19) == 0);
         @(negedge clk);
         clr = 1'b0;
         repeat ($urandom_range(0, 12)) @(negedge clk);
      end
      slider = '0;
      down   = 1'b0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
